// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and clear-controller state type for reg_file_pipe
package reg_file_pkg;
   localparam int DW_DEF  = 32;
   localparam int AW_DEF  = 6;
   localparam int NRD_DEF = 2;
   typedef enum logic {CLEAR, IDLE} clr_state_e;
endpackage

// File: rtl/reg_file_clear_ctl.sv
// reg_file_clear_ctl: zero-sweep sequencer (ports: clk_i, rst_n_i, clr_i in; busy_o, clr_addr_o, clr_we_o out)
module reg_file_clear_ctl
   import reg_file_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          clr_i,
   output logic          busy_o,
   output logic [AW-1:0] clr_addr_o,
   output logic          clr_we_o
);
   clr_state_e    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   // The last entry (all-ones cnt) ends the sweep; the wrapped cnt parks in IDLE.
   always_comb begin
      state_d = clr_i ? CLEAR : (state_q == CLEAR && &cnt_q) ? IDLE : state_q;
      cnt_d   = (clr_i || state_q == IDLE) ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   assign busy_o     = state_q == CLEAR;
   assign clr_we_o   = busy_o;
   assign clr_addr_o = cnt_q;
endmodule

// File: rtl/reg_file_pipe.sv
// reg_file_pipe: 2-write/NRD-read register file, 1-cycle registered reads, zero sweep on reset/clr_i; optional REG_FILE_BYPASS_EN forwarding (ports: clk_i, rst_n_i, ra_i, rd_o, we/wa/wd 1&2, clr_i, busy_o)
module reg_file_pipe
   import reg_file_pkg::*;
#(
   parameter int DW  = DW_DEF,
   parameter int AW  = AW_DEF,
   parameter int NRD = NRD_DEF
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [NRD*AW-1:0] ra_i,
   output logic [NRD*DW-1:0] rd_o,
   input  logic              we1_i,
   input  logic [AW-1:0]     wa1_i,
   input  logic [DW-1:0]     wd1_i,
   input  logic              we2_i,
   input  logic [AW-1:0]     wa2_i,
   input  logic [DW-1:0]     wd2_i,
   input  logic              clr_i,
   output logic              busy_o
);
   localparam int DEPTH = 2**AW;
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rd_d  [NRD];
   logic [DW-1:0] rd_q  [NRD];
   logic [AW-1:0] clr_addr;
   logic          clr_we;
   reg_file_clear_ctl #(.AW(AW)) u_clr (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .clr_i      (clr_i),
      .busy_o     (busy_o),
      .clr_addr_o (clr_addr),
      .clr_we_o   (clr_we)
   );
   // Array has no reset: the sweep defines it. Port 2 is assigned last so it wins a collision.
   always_ff @(posedge clk_i) begin
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else begin
         if (we1_i) mem_q[wa1_i] <= wd1_i;
         if (we2_i) mem_q[wa2_i] <= wd2_i;
      end
   end
   for (genvar n = 0; n < NRD; n++) begin : g_rd
      logic [AW-1:0] ra;
      logic [DW-1:0] val;
      assign ra = ra_i[n*AW +: AW];
`ifdef REG_FILE_BYPASS_EN
      assign val = (we2_i && wa2_i == ra) ? wd2_i : (we1_i && wa1_i == ra) ? wd1_i : mem_q[ra];
`else
      assign val = mem_q[ra];
`endif
      assign rd_d[n] = busy_o ? '0 : val;
      assign rd_o[n*DW +: DW] = rd_q[n];
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NRD; i++) rd_q[i] <= '0;
      end else begin
         for (int i = 0; i < NRD; i++) rd_q[i] <= rd_d[i];
      end
   end
endmodule

// File: tb/tb_reg_file_pipe.sv
// tb_reg_file_pipe: scoreboard bench for reg_file_pipe against a behavioural register-file model
module tb_reg_file_pipe;
   localparam int DW = 32;
   localparam int AW = 6;
   localparam int NRD = 2;
   localparam int DEPTH = 64;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NRD*AW-1:0] ra = '0;
   logic [NRD*DW-1:0] rd;
   logic we1 = 1'b0, we2 = 1'b0, clr = 1'b0;
   logic [AW-1:0] wa1 = '0, wa2 = '0;
   logic [DW-1:0] wd1 = '0, wd2 = '0;
   logic busy;
   always #5 clk = ~clk;
   reg_file_pipe #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .ra_i(ra), .rd_o(rd),
      .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
      .we2_i(we2), .wa2_i(wa2), .wd2_i(wd2),
      .clr_i(clr), .busy_o(busy)
   );
   typedef struct packed {
      logic [NRD*DW-1:0] rd;
      logic              busy;
   } exp_t;
   exp_t q[$];
   exp_t mx;
   int n_checks = 0;
   int n_fail = 0;
   logic [DW-1:0] model [DEPTH];
   int remaining;
   task automatic model_reset();
      remaining = DEPTH;
      foreach (model[i]) model[i] = '0;
   endtask
   // Called at a negedge: drives inputs for the next rising edge, predicts its outcome, then waits one cycle.
   task automatic step(input int c, input int e1, input int a1, input logic [DW-1:0] d1,
                       input int e2, input int a2, input logic [DW-1:0] d2,
                       input int r0, input int r1);
      exp_t x;
      logic [DW-1:0] v0, v1;
      bit b;
      clr = (c != 0); we1 = (e1 != 0); wa1 = AW'(a1); wd1 = d1;
      we2 = (e2 != 0); wa2 = AW'(a2); wd2 = d2;
      ra = {AW'(r1), AW'(r0)};
      b = remaining > 0;
      v0 = model[r0];
      v1 = model[r1];
      if (!b) begin
         if (e1 != 0) model[a1] = d1;
         if (e2 != 0) model[a2] = d2;
      end
`ifdef REG_FILE_BYPASS_EN
      v0 = model[r0];
      v1 = model[r1];
`endif
      x.rd = b ? '0 : {v1, v0};
      if (c != 0) begin
         remaining = DEPTH;
         foreach (model[i]) model[i] = '0;
      end else if (b) begin
         remaining--;
      end
      x.busy = remaining > 0;
      q.push_back(x);
      @(negedge clk);
   endtask
   task automatic idle(input int n, input int r0, input int r1);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, r0, r1);
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      n_checks++;
      if (rd !== '0) begin
         n_fail++;
         $display("FAIL reset_rd: got %h expected 0", rd);
      end
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_busy: got %b expected 1", busy);
      end
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         mx = q.pop_front();
         n_checks++;
         if (rd !== mx.rd) begin
            n_fail++;
            $display("FAIL rd @%0t: got %h expected %h", $time, rd, mx.rd);
         end
         n_checks++;
         if (busy !== mx.busy) begin
            n_fail++;
            $display("FAIL busy @%0t: got %b expected %b", $time, busy, mx.busy);
         end
      end
   end
   initial begin
      model_reset();
      @(negedge clk);
      do_reset();
      idle(66, 0, 31);
      idle(1, 63, 0);
      step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      idle(1, 5, 5);
      step(0, 1, 9, 32'h11111111, 1, 9, 32'h22222222, 0, 0);
      idle(1, 9, 5);
      step(0, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
      step(0, 1, 7, 32'h5A5A5A5A, 0, 0, 0, 7, 7);
      idle(1, 7, 9);
      step(0, 1, 3, 32'hCAFEF00D, 0, 0, 0, 3, 3);
      step(1, 0, 0, 0, 0, 0, 0, 3, 5);
      idle(19, 3, 5);
      step(1, 1, 3, 32'h33333333, 0, 0, 0, 3, 5);
      for (int i = 0; i < 10; i++) step(0, 1, 3, 32'h44444444 + DW'(i), 1, 4, 32'h1, 3, 4);
      idle(56, 3, 4);
      idle(2, 3, 5);
      step(0, 1, 10, 32'h0BADF00D, 0, 0, 0, 10, 10);
      idle(1, 10, 10);
      do_reset();
      idle(40, 10, 0);
      do_reset();
      idle(66, 10, 63);
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(127) == 0) ? 1 : 0,
              int'($urandom_range(1)), ($urandom_range(3) == 0) ? int'($urandom_range(63)) : int'($urandom_range(7)), $urandom(),
              int'($urandom_range(1)), int'($urandom_range(7)), $urandom(),
              int'($urandom_range(7)), ($urandom_range(3) == 0) ? int'($urandom_range(63)) : int'($urandom_range(7)));
      end
      idle(1, 0, 0);
      @(posedge clk);
      #2;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_file_pipe.md
REG_FILE_PIPE -- requirements
Module: reg_file_pipe

Interface
REQ-001 Parameter DW, default 32, data width in bits.
REQ-002 Parameter AW, default 6, address width; DEPTH = 2**AW entries (64).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 CLK  input  1  sole clock, all state updates on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 RA  input  NRD*AW  read addresses, port n at bits [n*AW +: AW].
REQ-007 RD  output  NRD*DW  read data, port n at bits [n*DW +: DW], registered.
REQ-008 WE1, WA1, WD1  input  1/AW/DW  write port 1 enable, address, data.
REQ-009 WE2, WA2, WD2  input  1/AW/DW  write port 2 enable, address, data.
REQ-010 CLR  input  1  single-cycle request to zero the whole array.
REQ-011 BUSY  output  1  high while the clear sweep is in progress.

Function
REQ-012 Read latency SHALL be exactly one cycle: RD port n at edge k+1 reflects RA port n sampled at edge k.
REQ-013 Writes SHALL commit on the rising edge when the port's WE is high and BUSY is low.
REQ-014 When WE1 and WE2 target the same address in one cycle, port 2 data SHALL be stored.
REQ-015 Clear controller SHALL have states CLEAR and IDLE; CLEAR writes zero to entry cnt and increments cnt by one per cycle.
REQ-016 CLEAR SHALL move to IDLE in the cycle after cnt = DEPTH-1 is written; BUSY is high for exactly DEPTH cycles.
REQ-017 CLR in IDLE SHALL enter CLEAR with cnt = 0 on the next edge; CLR during CLEAR SHALL restart cnt at 0.
REQ-018 While BUSY is high, WE1/WE2 SHALL be ignored (writes dropped, not queued), and all RD ports SHALL register zero.
REQ-019 cnt SHALL be AW bits wide and SHALL not wrap into a second sweep without a new CLR.
REQ-020 Read addresses are always in range (AW bits cover DEPTH); no out-of-range handling exists.

Reset
REQ-021 RST_N low SHALL immediately force RD to all zeros, BUSY to 1, state to CLEAR, cnt to 0.
REQ-022 On RST_N release, the clear sweep SHALL start on the first rising edge; array contents are only defined after BUSY falls.
REQ-023 RST_N asserted mid-sweep or mid-write SHALL abandon the operation and restart the sweep from cnt = 0.

Configuration
REQ-024 Macro REG_FILE_BYPASS_EN, when defined, SHALL forward same-cycle write data to a read of the same address (port 2 over port 1 over array).
REQ-025 Without REG_FILE_BYPASS_EN, a read of an address being written in the same cycle SHALL return the pre-write value.
REQ-026 Bypass SHALL never forward during BUSY; REQ-018 takes precedence.

Structure
REQ-027 Package reg_file_pkg SHALL hold the clear-state enum (CLEAR, IDLE) and default DW/AW/NRD constants.
REQ-028 Clear FSM and cnt SHALL live in sub-module reg_file_clear_ctl, outputting BUSY, clear address and clear write strobe.
REQ-029 Array and read/write muxing SHALL remain in reg_file_pipe; no other sub-modules.

Verification
REQ-030 Reset release -> BUSY high exactly 64 cycles, then low; read of addresses 0, 31, 63 returns 0x00000000.
REQ-031 WE1 addr 5 data 0xDEADBEEF, next cycle RA0 = 5 -> RD0 = 0xDEADBEEF one cycle later; RA1 = 5 simultaneously returns the same.
REQ-032 WE1 addr 9 0x11111111 and WE2 addr 9 0x22222222 same cycle -> later read of 9 returns 0x22222222.
REQ-033 Read addr 7 (holding 0xA5A5A5A5) while writing 0x5A5A5A5A to 7 -> RD = 0x5A5A5A5A with REG_FILE_BYPASS_EN, 0xA5A5A5A5 without.
REQ-034 CLR at sweep cycle 20, WE1 addr 3 during sweep -> BUSY stays high 64 further cycles; addr 3 reads 0 afterwards.
REQ-035 RST_N pulsed low at sweep cycle 40 -> RD zero asynchronously; BUSY high 64 cycles after release.
